// File: rtl/sha_512_pad_pkg.sv
// sha_const: shared state encoding, sizes and the padding word for the
// SHA-512 padding front end (sha_512_pad) and its mask helper.
package sha_const;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned BLK_WORDS = 16;
  localparam int unsigned WCNT_W    = 5;
  localparam int unsigned BLK_W     = 64;
  localparam int unsigned IDX_W     = 128;
  localparam int unsigned HASH_W    = 512;

  localparam logic [WORD_W-1:0] PAD_WORD = 64'h8000_0000_0000_0000;

  // One 1024-bit message block, word i at [i*64 +: 64].
  typedef logic [BLK_WORDS-1:0][WORD_W-1:0] block_t;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    PAD    = 2'd1,
    SEND   = 2'd2,
    WAIT   = 2'd3
  } state_e;

endpackage

// File: rtl/sha_512_pad_mask.sv
// sha_pad_mask: masks the final message word to its valid bytes and
// inserts the 0x80 pad byte right after them.
//   data_i   : final message word, byte 0 in [63:56]
//   bytes_i  : valid bytes 0..8, MSB-aligned
//   word_o_c : masked word with pad byte (data_i unchanged when full)
//   ovf_o_c  : word is full, pad byte belongs in the next word
module sha_pad_mask
  import sha_const::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic [3:0]        bytes_i,
  output logic [WORD_W-1:0] word_o_c,
  output logic              ovf_o_c
);

  always_comb begin
    word_o_c = data_i;
    ovf_o_c  = 1'b0;
    if (bytes_i >= 4'd8) begin
      ovf_o_c = 1'b1;
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (4'(b) > bytes_i) begin
          word_o_c[63-8*b -: 8] = 8'h00;
        end else if (4'(b) == bytes_i) begin
          word_o_c[63-8*b -: 8] = PAD_WORD[63:56];
        end
      end
    end
  end

endmodule

// File: rtl/sha_512_pad.sv
// sha_512_pad: FIPS 180-4 padding front end for the SHA-512 family core.
// Collects 64-bit big-endian message words into 1024-bit blocks, appends
// the 0x80 byte, zero fill and the 128-bit bit length, hands each block to
// the core and returns the final hash as a one-cycle digest strobe.
//   clk, rst                     : clock, async active-low reset
//   In_Data/Valid/Last/Bytes     : message word stream, In_Ready handshake
//   Mode                         : hash variant, sampled on first word
//   Out_Data/Index/Operation     : block, block number, variant to core
//   Out_Enable                   : one-cycle block start to core
//   Core_Ready, Core_Hash        : core done pulse and result
//   Digest, Digest_Valid         : final hash and one-cycle strobe
module sha_512_pad
  import sha_const::*;
#(
  parameter int unsigned LEN_W = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      In_Data,
  input  logic                   In_Valid,
  input  logic                   In_Last,
  input  logic [3:0]             In_Bytes,
  output logic                   In_Ready,
  input  logic [1:0]             Mode,
  output logic [WORD_W*16-1:0]   Out_Data,
  output logic [IDX_W-1:0]       Out_Index,
  output logic [1:0]             Out_Operation,
  output logic                   Out_Enable,
  input  logic                   Core_Ready,
  input  logic [HASH_W-1:0]      Core_Hash,
  output logic [HASH_W-1:0]      Digest,
  output logic                   Digest_Valid
);

  state_e              state_q, state_d;
  block_t              data_q, data_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d, wcnt_inc_c;
  logic [BLK_W-1:0]    blk_q, blk_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [1:0]          mode_q, mode_d;
  logic                final_q, final_d;
  logic                pend_pad_q, pend_pad_d;
  logic                pend_len_q, pend_len_d;
  logic                in_ready_q, in_ready_d;
  logic                out_enable_q, out_enable_d;
  logic [IDX_W-1:0]    out_index_q, out_index_d;
  logic [HASH_W-1:0]   digest_q, digest_d;
  logic                digest_valid_q, digest_valid_d;

  logic                hs_c;
  logic [WORD_W-1:0]   masked_c;
  logic                ovf_c;
  logic [6:0]          len_inc_c;
  logic [127:0]        len128_c;

  sha_pad_mask u_mask (
    .data_i   (In_Data),
    .bytes_i  (In_Bytes),
    .word_o_c (masked_c),
    .ovf_o_c  (ovf_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ACCEPT;
      data_q         <= '0;
      wcnt_q         <= '0;
      blk_q          <= BLK_W'(1);
      len_q          <= '0;
      mode_q         <= '0;
      final_q        <= 1'b0;
      pend_pad_q     <= 1'b0;
      pend_len_q     <= 1'b0;
      in_ready_q     <= 1'b0;
      out_enable_q   <= 1'b0;
      out_index_q    <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_q         <= data_d;
      wcnt_q         <= wcnt_d;
      blk_q          <= blk_d;
      len_q          <= len_d;
      mode_q         <= mode_d;
      final_q        <= final_d;
      pend_pad_q     <= pend_pad_d;
      pend_len_q     <= pend_len_d;
      in_ready_q     <= in_ready_d;
      out_enable_q   <= out_enable_d;
      out_index_q    <= out_index_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
    end
  end

  // Next-state, buffer update and registered-output decode.
  always_comb begin
    state_d        = state_q;
    data_d         = data_q;
    wcnt_d         = wcnt_q;
    blk_d          = blk_q;
    len_d          = len_q;
    mode_d         = mode_q;
    final_d        = final_q;
    pend_pad_d     = pend_pad_q;
    pend_len_d     = pend_len_q;
    out_index_d    = out_index_q;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
    hs_c           = In_Valid & in_ready_q;
    wcnt_inc_c     = wcnt_q + WCNT_W'(1);
    len_inc_c      = ovf_c ? 7'd64 : {In_Bytes, 3'b000};
    len128_c       = 128'(len_q);

    case (state_q)
      ACCEPT: begin
        if (hs_c) begin
          if (wcnt_q == '0 && blk_q == BLK_W'(1)) begin
            mode_d = Mode;
          end
          wcnt_d = wcnt_inc_c;
          if (!In_Last) begin
            data_d[wcnt_q[3:0]] = In_Data;
            len_d               = len_q + LEN_W'(64);
            if (wcnt_inc_c == WCNT_W'(16)) begin
              state_d = SEND;
            end
          end else begin
            // Bytes=0 yields PAD_WORD from the mask, covering the empty message.
            data_d[wcnt_q[3:0]] = masked_c;
            len_d               = len_q + LEN_W'(len_inc_c);
            state_d             = PAD;
            if (ovf_c) begin
              if (wcnt_inc_c == WCNT_W'(16)) begin
                pend_pad_d = 1'b1;
                state_d    = SEND;
              end else begin
                data_d[wcnt_inc_c[3:0]] = PAD_WORD;
                wcnt_d                  = wcnt_q + WCNT_W'(2);
              end
            end
          end
        end
      end

      // wcnt points one past the pad word; length fits if pad word <= 13.
      PAD: begin
        for (int i = 0; i < int'(BLK_WORDS); i++) begin
          if (WCNT_W'(i) >= wcnt_q) begin
            data_d[i] = '0;
          end
        end
        if (wcnt_q <= WCNT_W'(14)) begin
          data_d[14] = len128_c[127:64];
          data_d[15] = len128_c[63:0];
          final_d    = 1'b1;
        end else begin
          pend_len_d = 1'b1;
        end
        state_d = SEND;
      end

      SEND: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (Core_Ready) begin
          blk_d  = blk_q + BLK_W'(1);
          wcnt_d = '0;
          if (final_q) begin
            digest_d       = Core_Hash;
            digest_valid_d = 1'b1;
            blk_d          = BLK_W'(1);
            len_d          = '0;
            final_d        = 1'b0;
            pend_pad_d     = 1'b0;
            pend_len_d     = 1'b0;
            state_d        = ACCEPT;
          end else if (pend_pad_q) begin
            data_d[0]  = PAD_WORD;
            wcnt_d     = WCNT_W'(1);
            pend_pad_d = 1'b0;
            state_d    = PAD;
          end else if (pend_len_q) begin
            data_d     = '0;
            data_d[14] = len128_c[127:64];
            data_d[15] = len128_c[63:0];
            final_d    = 1'b1;
            pend_len_d = 1'b0;
            state_d    = SEND;
          end else begin
            state_d = ACCEPT;
          end
        end
      end

      default: state_d = ACCEPT;
    endcase

    in_ready_d   = (state_d == ACCEPT);
    out_enable_d = (state_d == SEND);
    if (state_d == SEND) begin
      out_index_d = IDX_W'(blk_d);
    end
  end

  assign In_Ready      = in_ready_q;
  assign Out_Data      = data_q;
  assign Out_Index     = out_index_q;
  assign Out_Operation = mode_q;
  assign Out_Enable    = out_enable_q;
  assign Digest        = digest_q;
  assign Digest_Valid  = digest_valid_q;

endmodule

// File: tb/tb_sha_512_pad.sv
// tb_sha_512_pad: directed bench for sha_512_pad. A behavioural core stand-in
// answers each Out_Enable with Core_Ready after a fixed latency and returns
// a simple chained fold of the blocks as its hash; expected blocks and the
// expected digest are built by hand from the padding rules.
module tb_sha_512_pad;

  localparam int LIM      = 400;
  localparam int CORE_LAT = 4;
  localparam logic [63:0] PADW = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ABC  = 64'h6162_6300_0000_0000;

  logic          clk;
  logic          rst;
  logic [63:0]   In_Data;
  logic          In_Valid;
  logic          In_Last;
  logic [3:0]    In_Bytes;
  logic          In_Ready;
  logic [1:0]    Mode;
  logic [1023:0] Out_Data;
  logic [127:0]  Out_Index;
  logic [1:0]    Out_Operation;
  logic          Out_Enable;
  logic          Core_Ready;
  logic [511:0]  Core_Hash;
  logic [511:0]  Digest;
  logic          Digest_Valid;

  sha_512_pad #(.LEN_W(128)) dut (
    .clk           (clk),
    .rst           (rst),
    .In_Data       (In_Data),
    .In_Valid      (In_Valid),
    .In_Last       (In_Last),
    .In_Bytes      (In_Bytes),
    .In_Ready      (In_Ready),
    .Mode          (Mode),
    .Out_Data      (Out_Data),
    .Out_Index     (Out_Index),
    .Out_Operation (Out_Operation),
    .Out_Enable    (Out_Enable),
    .Core_Ready    (Core_Ready),
    .Core_Hash     (Core_Hash),
    .Digest        (Digest),
    .Digest_Valid  (Digest_Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1023:0]       blk_log [0:63];
  logic [127:0]        idx_log [0:63];
  logic [1:0]          op_log  [0:63];
  int                  nblk = 0;
  logic [63:0]         msg [0:31];
  logic [15:0][63:0]   eb  [0:1];

  function automatic logic [511:0] iv(input logic [1:0] op);
    return {8{64'h0123_4567_89ab_cdef ^ {62'd0, op}}};
  endfunction

  function automatic logic [511:0] step(input logic [511:0] h, input logic [1023:0] b);
    return {h[510:0], h[511]} ^ b[1023:512] ^ b[511:0];
  endfunction

  function automatic logic [511:0] exp_digest(input logic [1:0] op, input int n);
    logic [511:0] h;
    h = iv(op);
    for (int k = 0; k < n; k++) h = step(h, eb[k]);
    return h;
  endfunction

  // Core stand-in: logs each block, pulses Core_Ready CORE_LAT cycles later.
  initial begin : core_model
    logic [511:0] core_h;
    Core_Ready = 1'b0;
    Core_Hash  = '0;
    core_h     = '0;
    forever begin
      if (Out_Enable === 1'b1) begin
        if (nblk < 64) begin
          blk_log[nblk] = Out_Data;
          idx_log[nblk] = Out_Index;
          op_log[nblk]  = Out_Operation;
        end
        nblk++;
        if (Out_Index == 128'd1) core_h = iv(Out_Operation);
        core_h = step(core_h, Out_Data);
        repeat (CORE_LAT) @(posedge clk);
        #1;
        Core_Ready = 1'b1;
        Core_Hash  = core_h;
        @(posedge clk);
        #1;
        Core_Ready = 1'b0;
        Core_Hash  = ~core_h;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no end of run, want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic fill_msg(input int n);
    for (int i = 0; i < n; i++) msg[i] = {32'(i + 1), 32'hA5A5_5A5A};
  endtask

  // Sends msg[0..n-1]; Mode flips after the first word to prove it is latched.
  task automatic send_msg(input int n, input logic [3:0] nb, input logic [1:0] md, output bit to);
    to = 1'b0;
    for (int i = 0; i < n; i++) begin
      int k;
      In_Data  = msg[i];
      In_Valid = 1'b1;
      In_Last  = (i == n - 1);
      In_Bytes = (i == n - 1) ? nb : 4'(i);
      Mode     = (i == 0) ? md : ~md;
      k = 0;
      while (In_Ready !== 1'b1 && k < LIM) begin
        @(posedge clk);
        #1;
        k++;
      end
      if (k >= LIM) begin
        to = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    In_Valid = 1'b0;
    In_Last  = 1'b0;
    In_Bytes = 4'd0;
  endtask

  task automatic wait_digest(output bit to);
    int k;
    k = 0;
    while (Digest_Valid !== 1'b1 && k < LIM) begin
      @(posedge clk);
      #1;
      k++;
    end
    to = (k >= LIM);
  endtask

  task automatic test_reset;
    rst = 1'b0; In_Valid = 1'b0; In_Last = 1'b0; In_Bytes = 4'd0; In_Data = '0; Mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", In_Ready); end
    checks++; if (Out_Enable !== 1'b0) begin errors++; $display("FAIL rst_out_enable: got %b want 0", Out_Enable); end
    checks++; if (Digest_Valid !== 1'b0) begin errors++; $display("FAIL rst_digest_valid: got %b want 0", Digest_Valid); end
    checks++; if (Out_Data !== '0) begin errors++; $display("FAIL rst_out_data: got nonzero want 0"); end
    checks++; if (Out_Index !== '0) begin errors++; $display("FAIL rst_out_index: got %h want 0", Out_Index); end
    checks++; if (Digest !== '0) begin errors++; $display("FAIL rst_digest: got %h want 0", Digest); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_abc;
    bit to; int base;
    base = nblk;
    msg[0] = ABC;
    send_msg(1, 4'd3, 2'd3, to);
    checks++; if (to) begin errors++; $display("FAIL abc_accept: got timeout want handshake"); end
    checks++; if (Out_Enable !== 1'b0) begin errors++; $display("FAIL abc_enable_early: got %b want 0", Out_Enable); end
    @(posedge clk);
    #1;
    checks++; if (Out_Enable !== 1'b1) begin errors++; $display("FAIL abc_enable_latency: got %b want 1", Out_Enable); end
    wait_digest(to);
    eb[0] = '0; eb[0][0] = 64'h6162_6380_0000_0000; eb[0][15] = 64'h18;
    checks++; if (to) begin errors++; $display("FAIL abc_digest_timeout: got none want Digest_Valid"); end
    checks++; if (Digest !== exp_digest(2'd3, 1)) begin errors++; $display("FAIL abc_digest: got %h want %h", Digest, exp_digest(2'd3, 1)); end
    checks++; if (nblk - base != 1) begin errors++; $display("FAIL abc_nblk: got %0d want 1", nblk - base); end
    for (int w = 0; w < 16; w++) begin
      checks++;
      if (blk_log[base][w*64 +: 64] !== eb[0][w]) begin errors++; $display("FAIL abc_w%0d: got %h want %h", w, blk_log[base][w*64 +: 64], eb[0][w]); end
    end
    checks++; if (idx_log[base] !== 128'd1) begin errors++; $display("FAIL abc_index: got %0d want 1", idx_log[base]); end
    checks++; if (op_log[base] !== 2'd3) begin errors++; $display("FAIL abc_op: got %0d want 3", op_log[base]); end
    @(posedge clk);
    #1;
    checks++; if (Digest_Valid !== 1'b0) begin errors++; $display("FAIL abc_strobe: got %b want 0", Digest_Valid); end
  endtask

  task automatic test_empty;
    bit to; int base;
    base = nblk;
    msg[0] = 64'hDEAD_BEEF_0123_4567;
    send_msg(1, 4'd0, 2'd3, to);
    wait_digest(to);
    eb[0] = '0; eb[0][0] = PADW;
    checks++; if (to) begin errors++; $display("FAIL empty_digest_timeout: got none want Digest_Valid"); end
    checks++; if (Digest !== exp_digest(2'd3, 1)) begin errors++; $display("FAIL empty_digest: got %h want %h", Digest, exp_digest(2'd3, 1)); end
    checks++; if (nblk - base != 1) begin errors++; $display("FAIL empty_nblk: got %0d want 1", nblk - base); end
    for (int w = 0; w < 16; w++) begin
      checks++;
      if (blk_log[base][w*64 +: 64] !== eb[0][w]) begin errors++; $display("FAIL empty_w%0d: got %h want %h", w, blk_log[base][w*64 +: 64], eb[0][w]); end
    end
  endtask

  // One- or two-block message of n words; checks block words, index and op.
  task automatic test_multi(input string nm, input int n, input logic [3:0] nb,
                            input logic [1:0] md, input int nexp);
    bit to; int base;
    base = nblk;
    send_msg(n, nb, md, to);
    checks++; if (to) begin errors++; $display("FAIL %s_accept: got timeout want handshakes", nm); end
    wait_digest(to);
    checks++; if (to) begin errors++; $display("FAIL %s_digest_timeout: got none want Digest_Valid", nm); end
    checks++; if (Digest !== exp_digest(md, nexp)) begin errors++; $display("FAIL %s_digest: got %h want %h", nm, Digest, exp_digest(md, nexp)); end
    checks++; if (nblk - base != nexp) begin errors++; $display("FAIL %s_nblk: got %0d want %0d", nm, nblk - base, nexp); end
    for (int k = 0; k < nexp; k++) begin
      for (int w = 0; w < 16; w++) begin
        checks++;
        if (blk_log[base+k][w*64 +: 64] !== eb[k][w]) begin errors++; $display("FAIL %s_b%0d_w%0d: got %h want %h", nm, k, w, blk_log[base+k][w*64 +: 64], eb[k][w]); end
      end
      checks++; if (idx_log[base+k] !== 128'(k + 1)) begin errors++; $display("FAIL %s_b%0d_index: got %0d want %0d", nm, k, idx_log[base+k], k + 1); end
      checks++; if (op_log[base+k] !== md) begin errors++; $display("FAIL %s_b%0d_op: got %0d want %0d", nm, k, op_log[base+k], md); end
    end
  endtask

  task automatic test_111;
    fill_msg(13); msg[13] = 64'hFFFF_FFFF_FFFF_FFFF;
    eb[0] = '0;
    for (int i = 0; i < 13; i++) eb[0][i] = msg[i];
    eb[0][13] = 64'hFFFF_FFFF_FFFF_FF80; eb[0][15] = 64'h378;
    test_multi("m111", 14, 4'd7, 2'd0, 1);
  endtask

  task automatic test_112;
    fill_msg(13); msg[13] = 64'h0011_2233_4455_6677;
    eb[0] = '0; eb[1] = '0;
    for (int i = 0; i < 14; i++) eb[0][i] = msg[i];
    eb[0][14] = PADW; eb[1][15] = 64'h380;
    test_multi("m112", 14, 4'd8, 2'd3, 2);
  endtask

  task automatic test_boundary;
    // 128 bytes: pad byte spills into a fresh block.
    fill_msg(16);
    eb[0] = '0; eb[1] = '0;
    for (int i = 0; i < 16; i++) eb[0][i] = msg[i];
    eb[1][0] = PADW; eb[1][15] = 64'h400;
    test_multi("m128", 16, 4'd8, 2'd1, 2);
    // 124 bytes: pad byte in word 15, length in a second block.
    fill_msg(16); msg[15] = 64'hCAFE_BABE_1234_5678;
    eb[0] = '0; eb[1] = '0;
    for (int i = 0; i < 15; i++) eb[0][i] = msg[i];
    eb[0][15] = 64'hCAFE_BABE_8000_0000; eb[1][15] = 64'h3E0;
    test_multi("m124", 16, 4'd4, 2'd0, 2);
  endtask

  task automatic test_back_to_back;
    // 162 bytes with In_Valid held through the first block's WAIT.
    fill_msg(20); msg[20] = 64'h1122_3344_5566_7788;
    eb[0] = '0; eb[1] = '0;
    for (int i = 0; i < 16; i++) eb[0][i] = msg[i];
    for (int i = 0; i < 4; i++) eb[1][i] = msg[16 + i];
    eb[1][4] = 64'h1122_8000_0000_0000; eb[1][15] = 64'h510;
    test_multi("m162", 21, 4'd2, 2'd1, 2);
    // Next message starts right on the Digest_Valid cycle.
    msg[0] = ABC;
    eb[0] = '0; eb[0][0] = 64'h6162_6380_0000_0000; eb[0][15] = 64'h18;
    test_multi("abc384", 1, 4'd3, 2'd2, 1);
  endtask

  task automatic test_reset_in_wait;
    bit to;
    msg[0] = ABC;
    send_msg(1, 4'd3, 2'd3, to);
    repeat (2) begin @(posedge clk); #1; end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (Out_Data !== '0) begin errors++; $display("FAIL arst_out_data: got nonzero want 0"); end
    checks++; if (Out_Index !== '0) begin errors++; $display("FAIL arst_out_index: got %h want 0", Out_Index); end
    checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL arst_in_ready: got %b want 0", In_Ready); end
    checks++; if (Digest !== '0) begin errors++; $display("FAIL arst_digest: got %h want 0", Digest); end
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    eb[0] = '0; eb[0][0] = 64'h6162_6380_0000_0000; eb[0][15] = 64'h18;
    test_multi("arst_abc", 1, 4'd3, 2'd3, 1);
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_111();
    test_112();
    test_boundary();
    test_back_to_back();
    test_reset_in_wait();
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
